xosera_bus_initiator: RTL and testbench
=======================================

XOSERA_BUS_INITIATOR -- requirements
Module: xosera_bus_initiator

Interface
REQ-001 SETUP_CYC, default 1, cycles with address/rd_nwr/bytesel/write data driven and bus_cs_n_o high before each strobe; legal range 1-15.
REQ-002 STROBE_CYC, default 4, cycles bus_cs_n_o is held low per byte cycle; legal range 1-15.
REQ-003 HOLD_CYC, default 1, cycles bus_cs_n_o is high with address/data still held after each strobe; legal range 1-15.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  in  1  transaction request.
REQ-007 req_ready_o  out  1  initiator idle and able to accept a request.
REQ-008 req_rd_nwr_i  in  1  1 = read, 0 = write.
REQ-009 req_reg_num_i  in  4  Xosera register number.
REQ-010 req_byte_i  in  1  1 = single odd-byte access, 0 = full 16-bit word access.
REQ-011 req_data_i  in  16  write data; [15:8] is the even byte and [7:0] is the odd byte.
REQ-012 rsp_valid_o  out  1  one-cycle transaction-complete pulse.
REQ-013 rsp_data_o  out  16  read result.
REQ-014 bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o  out  1 each  Xosera bus strobes.
REQ-015 bus_reg_num_o  out  4  bus register number.
REQ-016 bus_data_o  out  8  bus write data.
REQ-017 bus_data_oe_o  out  1  write-data output enable.
REQ-018 bus_data_i  in  8  bus read data.
REQ-019 bus_intr_i  in  1  asynchronous Xosera interrupt line.
REQ-020 intr_o  out  1  one-cycle pulse, interrupt rising edge.

Function
REQ-021 States SHALL be IDLE, SETUP, STROBE and HOLD, with a 4-bit down-counter loaded with the parameter value minus 1 on entry to SETUP, STROBE and HOLD.
REQ-022 req_ready_o SHALL be 1 only in IDLE; acceptance occurs when req_valid_i and req_ready_o are both 1, and all req_* fields SHALL be latched at acceptance only.
REQ-023 IDLE->SETUP on acceptance; SETUP->STROBE, STROBE->HOLD and HOLD->next each occur when the counter reaches 0.
REQ-024 HOLD->SETUP with bus_bytesel_o=1 when the even byte has just completed; otherwise HOLD->IDLE.
REQ-025 Word access: even byte (bytesel 0) SHALL be issued first, then odd byte (bytesel 1); byte access issues only the odd byte.
REQ-026 All bus_* outputs SHALL be registered.
REQ-027 bus_reg_num_o, bus_rd_nwr_o, bus_bytesel_o and bus_data_o SHALL remain stable from SETUP through HOLD of each byte.
REQ-028 bus_cs_n_o SHALL be 0 only in STROBE.
REQ-029 bus_data_oe_o SHALL be 1 from SETUP through HOLD of write transactions only, and 0 in IDLE and for all reads.
REQ-030 bus_data_o SHALL carry req_data_i[15:8] for bytesel 0 and [7:0] for bytesel 1.
REQ-031 Reads: bus_data_i SHALL be captured on the last STROBE cycle into rsp_data_o[15:8] (bytesel 0) or [7:0] (bytesel 1); for byte reads [15:8]=0.
REQ-032 Writes SHALL drive rsp_data_o=0.
REQ-033 Completion: rsp_valid_o pulses for one cycle in the first IDLE cycle after the final HOLD, i.e. cycle k+1+N*(SETUP_CYC+STROBE_CYC+HOLD_CYC) for acceptance in cycle k, with N=2 for word and N=1 for byte.
REQ-034 A new request MAY be accepted in the same cycle as rsp_valid_o.
REQ-035 req_valid_i while busy SHALL be ignored.
REQ-036 bus_intr_i SHALL pass through a 2-flop synchronizer; intr_o pulses for one cycle on a synchronized 0->1 transition, 3 clk edges after the input rises.

Reset
REQ-037 While reset_n_i=0 the block SHALL be asynchronously forced to IDLE with: bus_cs_n_o=1, bus_rd_nwr_o=1, bus_reg_num_o=0, bus_bytesel_o=0, bus_data_o=0, bus_data_oe_o=0, rsp_valid_o=0, rsp_data_o=0, intr_o=0, synchronizer=0, counter=0.
REQ-038 req_ready_o SHALL be 1 in reset.
REQ-039 Reset mid-transaction SHALL abort the transaction with no rsp_valid_o pulse.

Verification
REQ-040 Default params, write reg 3 data 0xA55A, accepted cycle 0 -> bytesel 0 / data 0xA5 / oe 1; cs_n low cycles 2-5; then bytesel 1 / data 0x5A with cs_n low cycles 8-11; rsp_valid_o at cycle 13.
REQ-041 Read reg 2, bus_data_i=0x12 during first strobe and 0x34 during second -> rsp_data_o=0x1234 with rsp_valid_o; oe never 1.
REQ-042 Byte write reg 5 data 0x00C7 -> single byte cycle, bytesel 1, data 0xC7, rsp_valid_o at cycle 7.
REQ-043 req_valid_i held high across two word requests -> second accepted in the first request's rsp_valid_o cycle; cs_n high for at least HOLD_CYC+SETUP_CYC+1 cycles between strobes.
REQ-044 reset_n_i low during the second STROBE -> cs_n=1 and oe=0 immediately; no rsp_valid_o; req_ready_o=1 after release.
REQ-045 STROBE_CYC=1, SETUP_CYC=HOLD_CYC=15 word read -> single-cycle cs_n pulses, rsp_valid_o at cycle 63; bus_intr_i rising and held 10 cycles -> exactly one intr_o pulse, 3 cycles later.

Source files
------------

// File: rtl/xosera_bus_initiator.sv
// xosera_bus_initiator
// Turns single request/response transactions into Xosera 8-bit bus cycles.
// A word access becomes two byte cycles: the even byte (bytesel 0) first,
// then the odd byte (bytesel 1). A byte access is one odd-byte cycle.
// Each byte cycle runs SETUP_CYC, then STROBE_CYC, then HOLD_CYC clocks.
// The interrupt line is synchronised and turned into a rising-edge pulse.
//
// Ports
//   clk, reset_n_i      : clock, asynchronous active-low reset
//   req_*               : request handshake and fields (latched on accept)
//   rsp_valid_o/data_o  : one-cycle completion pulse and read result
//   bus_*_o, bus_data_i : registered Xosera bus strobes and data
//   bus_intr_i, intr_o  : asynchronous interrupt in, one-cycle pulse out
module xosera_bus_initiator #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic        req_byte_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_intr_i,
  output logic        intr_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Counter reload values; each phase lasts (load + 1) cycles.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic [7:0]  odd_byte_q;
  logic        cs_n_q;
  logic        rd_nwr_q;
  logic        bytesel_q;
  logic [3:0]  reg_num_q;
  logic [7:0]  wdata_q;
  logic        oe_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic [1:0]  sync_q;
  logic        intr_prev_q;
  logic        intr_q;
  logic [7:0]  first_byte_d;

  // First byte on the bus: the odd byte for byte accesses, else the even byte.
  always_comb begin
    first_byte_d = 8'h00;
    if (req_byte_i) begin
      first_byte_d = req_data_i[7:0];
    end else begin
      first_byte_d = req_data_i[15:8];
    end
  end

  // Transaction FSM: sequences the byte cycles and drives every bus/response register.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      odd_byte_q  <= 8'h00;
      cs_n_q      <= 1'b1;
      rd_nwr_q    <= 1'b1;
      bytesel_q   <= 1'b0;
      reg_num_q   <= 4'h0;
      wdata_q     <= 8'h00;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            odd_byte_q <= req_data_i[7:0];
            rd_nwr_q   <= req_rd_nwr_i;
            bytesel_q  <= req_byte_i;
            reg_num_q  <= req_reg_num_i;
            wdata_q    <= first_byte_d;
            oe_q       <= ~req_rd_nwr_i;
            // Clearing here gives 0 for writes and a zero even byte for byte reads.
            rsp_data_q <= 16'h0000;
            cnt_q      <= SETUP_LD;
            ready_q    <= 1'b0;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 4'd0) begin
            cs_n_q  <= 1'b0;
            cnt_q   <= STROBE_LD;
            state_q <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 4'd0) begin
            // Last strobe cycle: the target's read data is sampled here.
            if (rd_nwr_q) begin
              if (bytesel_q) begin
                rsp_data_q[7:0] <= bus_data_i;
              end else begin
                rsp_data_q[15:8] <= bus_data_i;
              end
            end
            cs_n_q  <= 1'b1;
            cnt_q   <= HOLD_LD;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 4'd0) begin
            if (!bytesel_q) begin
              // Even byte done: run the odd byte cycle of the word.
              bytesel_q <= 1'b1;
              wdata_q   <= odd_byte_q;
              cnt_q     <= SETUP_LD;
              state_q   <= ST_SETUP;
            end else begin
              oe_q        <= 1'b0;
              rsp_valid_q <= 1'b1;
              ready_q     <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          cs_n_q  <= 1'b1;
          oe_q    <= 1'b0;
          ready_q <= 1'b1;
          cnt_q   <= 4'd0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Interrupt: two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q      <= 2'b00;
      intr_prev_q <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus_intr_i};
      intr_prev_q <= sync_q[1];
      intr_q      <= sync_q[1] & ~intr_prev_q;
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign bus_cs_n_o    = cs_n_q;
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_bytesel_o = bytesel_q;
  assign bus_reg_num_o = reg_num_q;
  assign bus_data_o    = wdata_q;
  assign bus_data_oe_o = oe_q;
  assign intr_o        = intr_q;

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// Testbench for xosera_bus_initiator: a register-file model of the Xosera
// target, a shadow-register reference model, and scoreboard queues popped
// by monitors when strobes and responses appear.
module tb_xosera_bus_initiator;
  localparam int S = 1, T = 4, H = 1, P = S + T + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, bus_intr;
  logic        req_valid, req_ready, req_rd, req_byte, rsp_valid;
  logic [3:0]  req_reg, rnum;
  logic [15:0] req_data, rsp_data;
  logic        cs_n, rd_nwr, bsel, oe, intr;
  logic [7:0]  bdata, bdin;
  logic        req_valid2, req_ready2, rsp_valid2, cs_n2, rd_nwr2, bsel2, oe2, intr2;
  logic [15:0] rsp_data2;
  logic [3:0]  rnum2;
  logic [7:0]  bdata2, bdin2;

  xosera_bus_initiator #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) u_dut (
    .clk(clk), .reset_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rd_nwr_i(req_rd), .req_reg_num_i(req_reg), .req_byte_i(req_byte), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .bus_cs_n_o(cs_n), .bus_rd_nwr_o(rd_nwr),
    .bus_bytesel_o(bsel), .bus_reg_num_o(rnum), .bus_data_o(bdata), .bus_data_oe_o(oe),
    .bus_data_i(bdin), .bus_intr_i(bus_intr), .intr_o(intr));

  xosera_bus_initiator #(.SETUP_CYC(15), .STROBE_CYC(1), .HOLD_CYC(15)) u_dut2 (
    .clk(clk), .reset_n_i(rst_n), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .req_rd_nwr_i(1'b1), .req_reg_num_i(4'd2), .req_byte_i(1'b0), .req_data_i(16'h0000),
    .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2), .bus_cs_n_o(cs_n2), .bus_rd_nwr_o(rd_nwr2),
    .bus_bytesel_o(bsel2), .bus_reg_num_o(rnum2), .bus_data_o(bdata2), .bus_data_oe_o(oe2),
    .bus_data_i(bdin2), .bus_intr_i(bus_intr), .intr_o(intr2));

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target model: register file, read data only valid in the last strobe cycle.
  logic [15:0] dev_mem [16];
  logic [15:0] shadow  [16];
  int scnt = 0;
  always @(posedge clk) scnt <= cs_n ? 0 : scnt + 1;
  assign bdin  = (!cs_n && scnt == T - 1) ? (bsel ? dev_mem[rnum][7:0] : dev_mem[rnum][15:8]) : 8'hEE;
  assign bdin2 = (!cs_n2) ? (bsel2 ? 8'h34 : 8'h12) : 8'hEE;

  typedef struct { logic rd; logic [3:0] rn; logic bs; logic [7:0] d; int start; } bus_exp_t;
  typedef struct { logic [15:0] d; int c; } rsp_exp_t;
  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int last_acc_cyc = 0, rsp_count = 0;

  // Acceptance: reference model builds expected bus cycles and response.
  // Response monitor: pops and compares on every rsp_valid pulse.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rsp_valid) begin
        rsp_count++;
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got rsp_valid expected none (cycle %0d)", cyc);
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          check("rsp_cycle", cyc, r.c);
          check("rsp_data", rsp_data, r.d);
        end
      end
      if (req_valid && req_ready) begin
        int nb;
        rsp_exp_t r;
        last_acc_cyc = cyc;
        nb = req_byte ? 1 : 2;
        for (int i = 0; i < nb; i++) begin
          bus_exp_t e;
          e.rd = req_rd; e.rn = req_reg;
          e.bs = req_byte ? 1'b1 : (i == 1);
          e.d  = e.bs ? req_data[7:0] : req_data[15:8];
          e.start = cyc + 1 + S + i * P;
          bus_q.push_back(e);
        end
        r.c = cyc + 1 + nb * P;
        if (!req_rd) begin
          r.d = 16'h0000;
          if (req_byte) shadow[req_reg][7:0] = req_data[7:0];
          else shadow[req_reg] = req_data;
        end else begin
          r.d = req_byte ? {8'h00, shadow[req_reg][7:0]} : shadow[req_reg];
        end
        rsp_q.push_back(r);
      end
    end
  end

  // Bus monitor: checks each strobe against the expected byte cycle; writes land in the target.
  initial begin
    logic prev_cs;
    int low;
    prev_cs = 1'b1; low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs = 1'b1;
      end else begin
        if (!cs_n && prev_cs) begin
          low = 1;
          if (bus_q.size() == 0) begin
            total++; bad++;
            $display("FAIL strobe_unexpected: got strobe expected none (cycle %0d)", cyc);
          end else begin
            bus_exp_t e;
            e = bus_q.pop_front();
            check("strobe_start", cyc, e.start);
            check("bus_reg_num", rnum, e.rn);
            check("bus_rd_nwr", rd_nwr, e.rd);
            check("bus_bytesel", bsel, e.bs);
            check("bus_oe", oe, !e.rd);
            if (!e.rd) begin
              check("bus_wdata", bdata, e.d);
              if (bsel) dev_mem[rnum][7:0] = bdata;
              else dev_mem[rnum][15:8] = bdata;
            end
          end
        end else if (!cs_n) begin
          low++;
        end else if (!prev_cs) begin
          check("strobe_len", low, T);
        end
        prev_cs = cs_n;
      end
    end
  end

  task automatic send(input logic rd, input logic [3:0] rn, input logic by, input logic [15:0] d);
    int t;
    req_rd = rd; req_reg = rn; req_byte = by; req_data = d; req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", rsp_q.size() + bus_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k1, k2, saved, n1, n2, first, pulses, wide, oe_seen, rcnt, rcyc;
    logic [15:0] rdat;
    logic prev2;
    rst_n = 1'b0; bus_intr = 1'b0; req_valid = 1'b0; req_rd = 1'b0; req_reg = 4'd0;
    req_byte = 1'b0; req_data = 16'h0000; req_valid2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dev_mem[i] = 16'($urandom);
      shadow[i]  = dev_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1'b1);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_rd_nwr", rd_nwr, 1'b1);
    check("rst_reg_num", rnum, 4'd0);
    check("rst_bytesel", bsel, 1'b0);
    check("rst_data", bdata, 8'h00);
    check("rst_oe", oe, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_intr", intr, 1'b0);
    check("rst_ready2", req_ready2, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: word write / read back, byte write / read back.
    send(1'b0, 4'd3, 1'b0, 16'hA55A); req_valid = 1'b0; drain();
    send(1'b1, 4'd3, 1'b0, 16'h0000); req_valid = 1'b0; drain();
    send(1'b0, 4'd2, 1'b0, 16'h1234); req_valid = 1'b0; drain();
    send(1'b1, 4'd2, 1'b0, 16'hFFFF); req_valid = 1'b0; drain();
    send(1'b0, 4'd5, 1'b1, 16'h00C7); req_valid = 1'b0; drain();
    send(1'b1, 4'd5, 1'b1, 16'h0000); req_valid = 1'b0; drain();

    // Back-to-back: second request accepted in the first's response cycle.
    send(1'b0, 4'd7, 1'b0, 16'($urandom)); k1 = last_acc_cyc;
    send(1'b0, 4'd8, 1'b0, 16'($urandom)); req_valid = 1'b0;
    check("b2b_accept", last_acc_cyc, k1 + 1 + 2 * P);
    drain();

    // Randomised traffic with random gaps, including held-valid back-to-back.
    for (int i = 0; i < 40; i++) begin
      int gap;
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom));
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        req_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    drain();

    // Reset during the second strobe of a word write.
    send(1'b0, 4'd9, 1'b0, 16'($urandom)); req_valid = 1'b0;
    k = last_acc_cyc;
    while (cyc < k + S + P + 2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_oe", oe, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    rsp_q.delete(); bus_q.delete();
    saved = rsp_count;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_ready_after", req_ready, 1'b1);
    check("abort_no_rsp", rsp_count, saved);
    send(1'b1, 4'd9, 1'b0, 16'h0000); req_valid = 1'b0; drain();

    // Interrupt: one pulse, three edges after the input rises.
    k = cyc; bus_intr = 1'b1;
    n1 = 0; n2 = 0; first = -1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (intr) begin n1++; if (first < 0) first = cyc; end
      if (intr2) n2++;
      if (j == 9) bus_intr = 1'b0;
    end
    check("intr_count", n1, 1);
    check("intr_cycle", first, k + 3);
    check("intr2_count", n2, 1);

    // Slow-setup, single-cycle-strobe word read on the second instance.
    @(posedge clk); #1;
    req_valid2 = 1'b1; k2 = cyc;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    pulses = 0; wide = 0; oe_seen = 0; rcnt = 0; rcyc = -1; rdat = 16'h0000; prev2 = 1'b1;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (!cs_n2 && prev2) pulses++;
      if (!cs_n2 && !prev2) wide++;
      if (oe2) oe_seen++;
      if (rsp_valid2) begin rcnt++; rcyc = cyc; rdat = rsp_data2; end
      prev2 = cs_n2;
    end
    check("slow_pulses", pulses, 2);
    check("slow_wide", wide, 0);
    check("slow_oe", oe_seen, 0);
    check("slow_rsp_count", rcnt, 1);
    check("slow_rsp_cycle", rcyc, k2 + 1 + 2 * (15 + 1 + 15));
    check("slow_rsp_data", rdat, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
